// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter that shares one external combinational float32 add/sub unit.
// Define FP_ARB_STATS_EN to add the op_count / stall_count statistics outputs.
module fp_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sbar,
  output logic [31:0]           au_a,
  output logic [31:0]           au_b,
  output logic                  au_sbar,
  input  logic [31:0]           au_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data
`ifdef FP_ARB_STATS_EN
  ,
  output logic [15:0]           op_count,
  output logic [15:0]           stall_count
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [31:0]     au_a_q, au_a_d;
  logic [31:0]     au_b_q, au_b_d;
  logic            au_sbar_q, au_sbar_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;

  logic            any_req_s;
  logic            grant_s;
  logic [ID_W-1:0] pick_s;
  logic [ID_W-1:0] ptr_inc_s;
  logic [31:0]     sel_a_s, sel_b_s;
  logic            sel_sbar_s;

  // Valid requester with the smallest circular distance from the pointer wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0]    p);
    int   best_d;
    int   d;
    logic take;
    rr_pick = '0;
    best_d  = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      d       = (j + NUM_REQ - int'(p)) % NUM_REQ;
      take    = v[j] && (d < best_d);
      best_d  = take ? d : best_d;
      rr_pick = take ? ID_W'(j) : rr_pick;
    end
  endfunction

  // Arbitration and operand selection for the current IDLE cycle.
  always_comb begin
    any_req_s  = |req_valid;
    pick_s     = rr_pick(req_valid, ptr_q);
    sel_a_s    = 32'h0000_0000;
    sel_b_s    = 32'h0000_0000;
    sel_sbar_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s    = sel_a_s    | ((pick_s == ID_W'(i)) ? req_a[32*i +: 32] : 32'h0000_0000);
      sel_b_s    = sel_b_s    | ((pick_s == ID_W'(i)) ? req_b[32*i +: 32] : 32'h0000_0000);
      sel_sbar_s = sel_sbar_s | ((pick_s == ID_W'(i)) ? req_sbar[i]       : 1'b0);
    end
  end

  // Gated by rst_n so no grant is visible while reset is held.
  assign grant_s   = rst_n && (state_q == ST_IDLE) && any_req_s;
  assign req_ready = grant_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s) : {NUM_REQ{1'b0}};
  assign ptr_inc_s = (gnt_q == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : gnt_q + ID_W'(1);

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    au_a_d      = au_a_q;
    au_b_d      = au_b_q;
    au_sbar_d   = au_sbar_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          au_a_d    = sel_a_s;
          au_b_d    = sel_b_s;
          au_sbar_d = sel_sbar_s;
          gnt_d     = pick_s;
          state_d   = ST_EXEC;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = au_c;
        rsp_id_d    = gnt_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ptr_inc_s;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {ID_W{1'b0}};
      gnt_q       <= {ID_W{1'b0}};
      au_a_q      <= 32'h0000_0000;
      au_b_q      <= 32'h0000_0000;
      au_sbar_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_data_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      au_a_q      <= au_a_d;
      au_b_q      <= au_b_d;
      au_sbar_q   <= au_sbar_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign au_a      = au_a_q;
  assign au_b      = au_b_q;
  assign au_sbar   = au_sbar_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef FP_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // op_count wraps naturally; stall_count saturates.
  always_comb begin
    op_count_d    = op_count_q;
    stall_count_d = stall_count_q;
    if (rsp_valid_q && rsp_ready) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
    if (any_req_s && !(|req_ready) && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q    <= 16'h0000;
      stall_count_q <= 16'h0000;
    end else begin
      op_count_q    <= op_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter with a table-driven stand-in for the add/sub unit.
module tb_fp_addsub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sbar;
  logic [31:0]           au_a, au_b, au_c;
  logic                  au_sbar;
  logic                  rsp_valid, rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
`ifdef FP_ARB_STATS_EN
  logic [15:0]           op_count, stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] op_a   [NUM_REQ];
  logic [31:0] op_b   [NUM_REQ];
  logic        op_s   [NUM_REQ];
  logic [31:0] exp_c  [NUM_REQ];

  fp_addsub_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sbar(req_sbar),
    .au_a(au_a), .au_b(au_b), .au_sbar(au_sbar), .au_c(au_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef FP_ARB_STATS_EN
    , .op_count(op_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Hand-computed float32 results for the operand pairs used here.
  function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    case ({a, b, s})
      {32'h3f80_0000, 32'h3f80_0000, 1'b0}: fp_ref = 32'h4000_0000;
      {32'h4000_0000, 32'h4100_0000, 1'b0}: fp_ref = 32'h4120_0000;
      {32'h4100_0000, 32'h4000_0000, 1'b1}: fp_ref = 32'h40c0_0000;
      {32'h3f80_0000, 32'h4040_0000, 1'b0}: fp_ref = 32'h4080_0000;
      default:                              fp_ref = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign au_c = fp_ref(au_a, au_b, au_sbar);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One full transaction whose grant is expected in the current IDLE cycle.
  task automatic run_op(input int id, input bit drop);
    check("grant", 32'(req_ready), 32'(4'b0001 << id));
    step();
    if (drop) req_valid[id] = 1'b0;
    #1;
    check("exec_ready", 32'(req_ready), 32'd0);
    check("exec_valid", 32'(rsp_valid), 32'd0);
    check("au_a", au_a, op_a[id]);
    check("au_b", au_b, op_b[id]);
    check("au_sbar", 32'(au_sbar), 32'(op_s[id]));
    step();
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_data", rsp_data, exp_c[id]);
    check("resp_ready", 32'(req_ready), 32'd0);
    step();
    check("retire", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_a[0] = 32'h3f80_0000; op_b[0] = 32'h3f80_0000; op_s[0] = 1'b0; exp_c[0] = 32'h4000_0000;
    op_a[1] = 32'h4000_0000; op_b[1] = 32'h4100_0000; op_s[1] = 1'b0; exp_c[1] = 32'h4120_0000;
    op_a[2] = 32'h4100_0000; op_b[2] = 32'h4000_0000; op_s[2] = 1'b1; exp_c[2] = 32'h40c0_0000;
    op_a[3] = 32'h3f80_0000; op_b[3] = 32'h4040_0000; op_s[3] = 1'b0; exp_c[3] = 32'h4080_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[32*i +: 32] = op_a[i];
      req_b[32*i +: 32] = op_b[i];
      req_sbar[i]       = op_s[i];
    end
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_au_a", au_a, 32'd0);
    check("rst_au_b", au_b, 32'd0);
    check("rst_au_sbar", 32'(au_sbar), 32'd0);
    rst_n = 1'b1;

    // single add, then subtract from requester 2
    req_valid = 4'b0001; #1; run_op(0, 1'b1);
    req_valid = 4'b0100; #1; run_op(2, 1'b1);

    // round robin with everyone valid from reset
    rst_n = 1'b0; req_valid = 4'b1111; #1;
    check("rst_hold_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1; #1;
    for (int k = 0; k < 5; k++) run_op(k % NUM_REQ, 1'b0);

    // backpressure: pointer now 1
    req_valid = 4'b0011; rsp_ready = 1'b0; #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0001;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", rsp_data, 32'h4120_0000);
      check("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1; #1;
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    step();
    check("bp_next_grant", 32'(req_ready), 32'b0001);
    run_op(0, 1'b1);

    // reset during EXEC
    req_valid = 4'b0010; #1;
    check("mid_grant", 32'(req_ready), 32'b0010);
    step();
    rst_n = 1'b0; #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    check("mid_au_a", au_a, 32'd0);
    check("mid_rsp_data", rsp_data, 32'd0);
    req_valid = 4'b0000;
    step();
    rst_n = 1'b1; req_valid = 4'b1000; #1;
    run_op(3, 1'b1);

    // three ops, two contending requesters
    rst_n = 1'b0; step(); rst_n = 1'b1; #1;
`ifdef FP_ARB_STATS_EN
    check("op_count_rst", 32'(op_count), 32'd0);
    check("stall_count_rst", 32'(stall_count), 32'd0);
`endif
    req_valid = 4'b0011; #1;
    run_op(0, 1'b1);
    run_op(1, 1'b1);
    repeat (2) step();
    req_valid = 4'b0100; #1;
    run_op(2, 1'b1);
`ifdef FP_ARB_STATS_EN
    check("op_count", 32'(op_count), 32'd3);
    check("stall_count", 32'(stall_count), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
